// File: rtl/prg_arbiter_pkg.sv
// prg_arbiter_pkg: shared state encodings and defaults for the generator arbiter
package prg_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DELIVER = 2'd2} state_t;
  localparam int TIMEOUT_DEF = 64;
  localparam int PRG_LATENCY = 3;
endpackage

// File: rtl/prg_arbiter_prg.sv
// PseudorandomGenerator: 32-bit LFSR reloaded from in_seed while idle, done after PRG_LATENCY start cycles
module PseudorandomGenerator import prg_arbiter_pkg::*; (
  input  logic        clk,
  input  logic        start,
  input  logic [31:0] in_seed,
  output logic [7:0]  value,
  output logic        done
);
  logic [31:0] lfsr;
  logic [1:0] cnt;
  always_ff @(posedge clk) begin
    lfsr <= start ? {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]} : (in_seed == '0 ? 32'h1 : in_seed);
    cnt <= start ? cnt + 2'd1 : 2'd0;
  end
  assign done = start && cnt == 2'(PRG_LATENCY - 1);
  assign value = lfsr[7:0];
endmodule

// File: rtl/prg_arbiter.sv
// prg_arbiter: round-robin arbiter sharing one pseudorandom byte generator among NUM_REQ requesters
module prg_arbiter import prg_arbiter_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                seed,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic [7:0]                 value,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [15:0]                grant_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t st;
  logic [IW-1:0] last_served, off, win;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] rot;
  logic gen_start, gen_done;
  logic [7:0] gen_value;
  assign busy = st != S_IDLE;
  assign gen_start = st == S_BUSY;
  // bit 0 of rot is the requester just after last_served; the lowest set bit wins
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < NUM_REQ; i++) rot[i] = req[IW'((int'(last_served) + 1 + i) % NUM_REQ)];
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
  end
  assign win = IW'((int'(last_served) + 1 + int'(off)) % NUM_REQ);
  PseudorandomGenerator u_prg (
    .clk     (clk),
    .start   (gen_start),
    .in_seed (seed),
    .value   (gen_value),
    .done    (gen_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_IDLE;
      ack <= '0;
      value <= '0;
      grant_id <= '0;
      timeout_err <= 1'b0;
      grant_count <= '0;
      cnt <= '0;
      last_served <= IW'(NUM_REQ - 1);
    end else begin
      ack <= '0;
      timeout_err <= 1'b0;
      case (st)
        S_IDLE: if (|req) begin
          grant_id <= win;
          cnt <= '0;
          st <= S_BUSY;
        end
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          // done beats a timeout landing in the same cycle
          if (gen_done || cnt == CW'(TIMEOUT - 1)) begin
            value <= gen_done ? gen_value : 8'h00;
            timeout_err <= !gen_done;
            ack <= NUM_REQ'(1) << grant_id;
            last_served <= grant_id;
            if (grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
            st <= S_DELIVER;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/prg_arbiter.md
PRG_ARBITER -- requirements
Module: prg_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the pseudorandom generator (2..8).
REQ-002 Parameter TIMEOUT, default 64, maximum cycles in BUSY while waiting for the generator's done.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seed  input  32  seed passed unmodified to the generator's in_seed.
REQ-006 req  input  NUM_REQ  per-requester level request for one 8-bit random value.
REQ-007 ack  output  NUM_REQ  one-hot, one-cycle pulse to the served requester.
REQ-008 value  output  8  random byte, valid only in the cycle ack is non-zero.
REQ-009 grant_id  output  clog2(NUM_REQ)  index of the requester currently or last served.
REQ-010 busy  output  1  high in BUSY and DELIVER.
REQ-011 timeout_err  output  1  one-cycle pulse coincident with an ack issued on timeout.
REQ-012 grant_count  output  16  saturating count of acks issued since reset.

Function
REQ-013 The FSM shall have three states: IDLE, BUSY and DELIVER.
REQ-014 In IDLE with req nonzero, the block shall pick a winner round-robin, searching from (last_served+1) mod NUM_REQ upward with wrap, register it into grant_id, and enter BUSY next cycle.
REQ-015 In IDLE with req zero, the block shall stay in IDLE with ack=0.
REQ-016 In BUSY, the generator start shall be held high every cycle; the block shall return to low on leaving BUSY.
REQ-017 In BUSY, a cycle counter shall increment each cycle from 0.
REQ-018 In BUSY, when the generator's done is high, the generator value shall be captured into value and the state shall go to DELIVER.
REQ-019 In BUSY, if the counter reaches TIMEOUT-1 without done, value shall be set to 0x00, a timeout flag shall be latched and the state shall go to DELIVER.
REQ-020 If done and the timeout both occur in the same cycle, done shall win: the captured byte is used and no error is flagged.
REQ-021 In DELIVER, for exactly one cycle, ack[grant_id]=1, timeout_err=latched flag, last_served=grant_id, grant_count increments (holding at 0xFFFF), then the state shall go to IDLE.
REQ-022 Request-to-ack latency shall be 1 (IDLE) + N (BUSY, generator latency) + 1 (DELIVER) cycles; the minimum is 3.
REQ-023 A request dropped during BUSY shall not abort the transaction; ack shall still pulse.
REQ-024 A requester holding req through its ack shall be re-arbitrated fairly in the next IDLE and shall not win twice in a row if another req is pending.
REQ-025 req changes in BUSY or DELIVER shall be ignored until IDLE.
REQ-026 value shall hold its last captured byte outside DELIVER.

Reset
REQ-027 On reset the outputs shall be: state=IDLE, ack=0, value=0x00, grant_id=0, busy=0, timeout_err=0, grant_count=0, generator start=0, BUSY counter=0.
REQ-028 On reset, last_served shall be NUM_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted during BUSY or DELIVER shall abandon the transaction with no ack issued, and the block shall be in IDLE on the first cycle after reset.

Structure
REQ-030 State encodings (IDLE=0, BUSY=1, DELIVER=2) and the TIMEOUT default shall live in the shared GA constants package.
REQ-031 The block shall contain exactly one sub-module, PseudorandomGenerator (clk, start, in_seed, value, done), instantiated internally.
REQ-032 The round-robin search shall be combinational over a rotated req vector; it shall have no additional sub-module.

Verification
REQ-033 Reset, then req=0001 -> ack=0001 three or more cycles later, value equals the generator output, grant_count=1.
REQ-034 req=1111 held for 8 acks -> ack order shall be 0,1,2,3,0,1,2,3.
REQ-035 req=0101 held -> acks shall alternate between requesters 0 and 2, with no grants to 1 or 3.
REQ-036 Generator done forced low -> ack after TIMEOUT+2 cycles with value=0x00 and timeout_err=1 in the same cycle.
REQ-037 Reset asserted in BUSY with req=0010 -> no ack, busy=0 the next cycle, and a fresh transaction completes after reset is released.
REQ-038 Force grant_count to 0xFFFE, then issue 3 acks -> grant_count shall be 0xFFFF and stay there.
